grf_wb_arbiter: RTL

- Shares the single write port of the 32x32 general register file (grf) between two writers: the main pipeline writeback and the multi-cycle mult/div unit (MDU).
- The pipeline has absolute priority. MDU results are buffered in a small FIFO and drained into idle write slots.
- A 32-bit busy scoreboard tracks registers with outstanding MDU results, so decode can stall on RAW/WAW hazards.
- Sits between the writeback stage/MDU and the grf; its outputs drive the grf write_enable/a3/wd3 inputs directly.

---
 rtl/grf_wb_arbiter_pkg.sv | 22 ++
 rtl/grf_wb_fifo.sv | 59 +++++
 rtl/grf_wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_arbiter shared types: register/data widths and the queued MDU
// writeback entry, plus a helper that spots writes to the hardwired $0.
package grf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef struct packed {
        reg_addr_t a3;
        data_t     wd;
    } wb_entry_t;

    // $0 is hardwired; any write to it is dropped everywhere.
    function automatic logic is_null(input reg_addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: DEPTH-entry synchronous FIFO of MDU writeback entries.
// Ports: clk, reset (async, active-low), push/din, pop/dout, full, empty.
// The caller must never push while full unless it pops in the same cycle.
module grf_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    // DEPTH is a power of two, so "full" is just the top count bit.
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the grf write port between the pipeline writeback
// (absolute priority) and the MDU, whose results queue in a small FIFO.
// Ports: clk, reset (async, active-low);
//   pipe_we/pipe_a3/pipe_wd      pipeline writeback
//   mdu_valid/mdu_a3/mdu_wd      MDU result, mdu_ready = FIFO can accept
//   issue_valid/issue_a3         MDU op issued by decode (marks dest busy)
//   chk_a1/chk_a2/chk_a3, hazard decode lookup against the busy scoreboard
//   stall_req                    ask upstream for a bubble to drain the FIFO
//   grf_we/grf_a3/grf_wd         straight to the grf write port
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_a3,
    input  logic [DATA_W-1:0]     pipe_wd,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_a3,
    input  logic [DATA_W-1:0]     mdu_wd,
    output logic                  mdu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_a3,
    input  logic [REG_ADDR_W-1:0] chk_a1,
    input  logic [REG_ADDR_W-1:0] chk_a2,
    input  logic [REG_ADDR_W-1:0] chk_a3,
    output logic                  hazard,
    output logic                  stall_req,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0]     grf_wd
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic           pipe_live;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    wb_entry_t      mdu_entry;
    wb_entry_t      head;
    logic [SW-1:0]  starve_q;
    logic [SW-1:0]  starve_d;
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // ---------------- arbitration ----------------
    assign pipe_live = pipe_we && !is_null(pipe_a3);

    // Any slot the pipeline leaves idle drains the FIFO head.
    assign fifo_pop  = !fifo_empty && !pipe_live;

    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign mdu_ready = !fifo_full || fifo_pop;
    assign fifo_push = mdu_valid && mdu_ready && !is_null(mdu_a3);

    assign mdu_entry.a3 = mdu_a3;
    assign mdu_entry.wd = mdu_wd;

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mdu_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The pipeline path is combinational; masking with reset keeps a
    // stray pipe_we from reaching the grf while the block is held.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        if (reset) begin
            unique case (1'b1)
                pipe_live: begin
                    grf_we = 1'b1;
                    grf_a3 = pipe_a3;
                    grf_wd = pipe_wd;
                end
                fifo_pop: begin
                    grf_we = 1'b1;
                    grf_a3 = head.a3;
                    grf_wd = head.wd;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- starvation ----------------
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Decoded only from flops, so it carries no path from this
    // cycle's inputs back into the upstream stall logic.
    assign stall_req = (starve_q == STARVE_MAX) || fifo_full;

    // ---------------- busy scoreboard ----------------
    // Clear first so a same-cycle reissue to the draining register wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head.a3] = 1'b0;
        end
        if (issue_valid && !is_null(issue_a3)) begin
            busy_d[issue_a3] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard = busy_q[chk_a1] | busy_q[chk_a2] | busy_q[chk_a3];

endmodule
